// File: rtl/battery_level_monitor.sv
// Battery level monitor: samples the five active-low level lines, debounces the
// decoded code and drives level/change/LED-bar/alarm/error outputs.
module battery_level_monitor #(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned BLINK_HALF    = 25000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       critic_level,
  input  logic       low_level,
  input  logic       medium_level,
  input  logic       high_level,
  input  logic       full,
  output logic [2:0] level,
  output logic       level_valid,
  output logic       level_chg,
  output logic       level_up,
  output logic [4:0] bar,
  output logic       alarm,
  output logic       err
);

  localparam int unsigned CW = $clog2(STABLE_CYCLES + 1);
  localparam int unsigned BW = $clog2(BLINK_HALF + 1);
  localparam logic [2:0] INVALID = 3'd7;

  typedef enum logic [1:0] {INIT, VALID, ERROR} state_t;

  state_t          state;
  logic [4:0]      s;
  logic [2:0]      dec;
  logic [2:0]      cand;
  logic [CW-1:0]   cnt;
  logic [BW-1:0]   bcnt;
  logic            accept;

  // s = {full, high, medium, low, critic}; exactly one low bit is a legal level
  always_comb begin
    dec = INVALID;
    case (s)
      5'b11110: dec = 3'd0;
      5'b11101: dec = 3'd1;
      5'b11011: dec = 3'd2;
      5'b10111: dec = 3'd3;
      5'b01111: dec = 3'd4;
      default:  dec = INVALID;
    endcase
  end

  assign accept = (dec == cand) && (cnt == CW'(STABLE_CYCLES - 1));

  function automatic logic [4:0] therm(input logic [2:0] l);
    case (l)
      3'd0:    therm = 5'b00001;
      3'd1:    therm = 5'b00011;
      3'd2:    therm = 5'b00111;
      3'd3:    therm = 5'b01111;
      3'd4:    therm = 5'b11111;
      default: therm = 5'b00000;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= INIT;
      s           <= '1;
      cand        <= INVALID;
      cnt         <= '0;
      bcnt        <= '0;
      level       <= '0;
      level_valid <= 1'b0;
      level_chg   <= 1'b0;
      level_up    <= 1'b0;
      bar         <= '0;
      alarm       <= 1'b0;
      err         <= 1'b0;
    end else begin
      s <= {full, high_level, medium_level, low_level, critic_level};

      if (dec == cand) begin
        if (cnt != CW'(STABLE_CYCLES)) cnt <= cnt + 1'b1;
      end else begin
        cand <= dec;
        cnt  <= CW'(1);
      end

      level_chg <= 1'b0;
      if (accept && dec == INVALID) begin
        state       <= ERROR;
        err         <= 1'b1;
        level_valid <= 1'b0;
        bar         <= '0;
        alarm       <= 1'b0;
        bcnt        <= '0;
      end else if (accept && (state != VALID || dec != level)) begin
        // Any transition into VALID or to a new code counts as a change
        state       <= VALID;
        err         <= 1'b0;
        level_valid <= 1'b1;
        level       <= dec;
        bar         <= therm(dec);
        level_chg   <= 1'b1;
        level_up    <= (state == INIT) ? 1'b1 : (dec > level);
        alarm       <= (dec == 3'd0);
        bcnt        <= '0;
      end else if (state == VALID && level == 3'd0) begin
        if (bcnt == BW'(BLINK_HALF - 1)) begin
          alarm <= ~alarm;
          bcnt  <= '0;
        end else begin
          bcnt <= bcnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_battery_level_monitor.sv
// Randomized scoreboard bench for battery_level_monitor against a run-length
// reference model of the level debouncer, state rules and alarm blink.
module tb_battery_level_monitor;

  localparam int S  = 4;
  localparam int BH = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] pin = '1;   // {full, high, medium, low, critic}, active low
  logic [2:0] level;
  logic       level_valid, level_chg, level_up, alarm, err;
  logic [4:0] bar;

  battery_level_monitor #(.STABLE_CYCLES(S), .BLINK_HALF(BH)) dut (
    .clk(clk), .rst(rst),
    .critic_level(pin[0]), .low_level(pin[1]), .medium_level(pin[2]),
    .high_level(pin[3]), .full(pin[4]),
    .level(level), .level_valid(level_valid), .level_chg(level_chg),
    .level_up(level_up), .bar(bar), .alarm(alarm), .err(err)
  );

  always #5 clk = ~clk;

  logic [13:0] expq[$];
  int checks = 0;
  int fails  = 0;

  // reference model state
  int m_level = 0, m_valid = 0, m_err = 0, m_up = 0, m_chg = 0, m_alarm = 0;
  int s_code = 7, last = 7, run = 0, t = 0;

  function automatic int decode_pat(input logic [4:0] p);
    if ($countones(~p) != 1) return 7;
    for (int k = 0; k < 5; k++) if (!p[k]) return k;
    return 7;
  endfunction

  function automatic logic [13:0] pack_exp();
    logic [4:0] b;
    b = m_valid ? 5'((1 << (m_level + 1)) - 1) : 5'd0;
    return {3'(m_level), 1'(m_valid), 1'(m_chg), 1'(m_up), b, 1'(m_alarm), 1'(m_err)};
  endfunction

  // Expected outputs after the next rising edge, given inputs/rst held across it
  task automatic step(input logic [4:0] p, input logic r);
    int d;
    if (r) begin
      m_level = 0; m_valid = 0; m_err = 0; m_up = 0; m_chg = 0; m_alarm = 0;
      s_code = 7; last = 7; run = 0; t = 0;
    end else begin
      d = s_code;
      if (run == 0 || d != last) begin
        last = d;
        run  = 1;
      end else if (run <= S) begin
        run++;
      end
      m_chg = 0;
      if (run == S) begin
        if (d == 7) begin
          m_err = 1; m_valid = 0;
        end else if (!m_valid || d != m_level) begin
          m_up    = (!m_valid && !m_err) ? 1 : (d > m_level);
          m_chg   = 1;
          m_level = d;
          m_valid = 1;
          m_err   = 0;
        end
      end
      if (m_valid && m_level == 0) begin
        if (m_chg) t = 0; else t++;
        m_alarm = ((t / BH) % 2) == 0;
      end else begin
        m_alarm = 0;
      end
      s_code = decode_pat(p);
    end
    expq.push_back(pack_exp());
  endtask

  task automatic drive(input logic [4:0] p, input logic r);
    @(negedge clk);
    pin = p;
    rst = r;
    step(p, r);
  endtask

  task automatic hold(input logic [4:0] p, input int n);
    for (int i = 0; i < n; i++) drive(p, 1'b0);
  endtask

  function automatic logic [4:0] onehot_low(input int k);
    logic [4:0] p;
    p = '1;
    p[k] = 1'b0;
    return p;
  endfunction

  // Monitor: every output cycle is a presented response
  initial begin
    logic [13:0] e, g;
    forever begin
      @(posedge clk);
      #1;
      if (expq.size() > 0) begin
        e = expq.pop_front();
        g = {level, level_valid, level_chg, level_up, bar, alarm, err};
        checks++;
        if (g !== e) begin
          fails++;
          $display("FAIL outputs t=%0t {level,valid,chg,up,bar,alarm,err} got=%b_%b_%b_%b_%b_%b_%b required=%b_%b_%b_%b_%b_%b_%b",
                   $time, g[13:11], g[10], g[9], g[8], g[7:3], g[2], g[1],
                   e[13:11], e[10], e[9], e[8], e[7:3], e[2], e[1]);
        end
      end
    end
  end

  initial begin
    int code, len, sel, budget;
    logic [4:0] p;
    drive('1, 1'b1);
    drive('1, 1'b1);
    // directed: medium, short low glitch, high, long critic blink, full
    hold(onehot_low(2), 8);
    hold(onehot_low(1), 2);
    hold(onehot_low(2), 3);
    hold(onehot_low(3), 7);
    hold(onehot_low(0), 14);
    hold(onehot_low(4), 7);
    // illegal patterns then recovery to the same level
    hold(5'b11111, 6);
    hold(5'b00111, 6);
    hold(onehot_low(4), 7);
    // reset during blink and mid-debounce
    hold(onehot_low(0), 10);
    hold(onehot_low(3), 2);
    drive(onehot_low(3), 1'b1);
    hold(onehot_low(3), 7);
    // walk up and back down one step
    for (int k = 0; k < 5; k++) hold(onehot_low(k), 6);
    hold(onehot_low(3), 6);
    // randomized phases
    for (int ph = 0; ph < 500; ph++) begin
      sel = $urandom_range(0, 11);
      if (sel < 8) begin
        code = $urandom_range(0, 4);
        p = onehot_low(code);
      end else if (sel < 10) begin
        p = 5'b11111;
      end else begin
        p = 5'($urandom_range(0, 31));
      end
      len = (p == 5'b11110) ? $urandom_range(1, 16) : $urandom_range(1, 9);
      if ($urandom_range(0, 40) == 0) drive(p, 1'b1);
      hold(p, len);
    end
    hold('1, 3);
    budget = 20;
    while (expq.size() > 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (expq.size() > 0) begin
      checks++;
      fails++;
      $display("FAIL drain leftover=%0d required=0", expq.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
